spi_slave_if: RTL and testbench

- Serial-to-parallel SPI slave front end that sits directly upstream of the single-port RAM in the SPI wrapper.
- Deserialises MOSI frames into {opcode[1:0], payload[DATA_W-1:0]} words and pulses rx_valid to the RAM.
- On read-data frames, captures the RAM's tx_data/tx_valid response and shifts it out on MISO, MSB first.
- SPI mode 0 equivalent: all sampling and driving happens on the rising edge of the system clk; SS_n and MOSI are already synchronous to clk.

---
 rtl/spi_slave_if.sv | 184 ++++++++++++++++++
 tb/tb_spi_slave_if.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/spi_slave_if.sv
// SPI slave front end: deserialises {opcode, payload} frames for the RAM and shifts read data back out on MISO.
// Optional SPI_FRAME_ERR_EN adds a frame_err strobe for truncated frames and select/opcode disagreement.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | no frame in progress, waiting for SS_n low
// CHK_CMD   | sampling the select bit that picks write or read handling
// WRITE     | receiving a write-address or write-data word
// READ_ADD  | receiving a read-address word; marks the address as seen
// READ_DATA | receiving the read-data request, then returning tx_data on MISO
module spi_slave_if #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              SS_n,
    input  logic              MOSI,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
`ifdef SPI_FRAME_ERR_EN
    output logic              frame_err,
`endif
    output logic              MISO,
    output logic [DATA_W+1:0] rx_data,
    output logic              rx_valid
);

    localparam int RX_BITS = DATA_W + 2;
    localparam int CNT_W   = $clog2(RX_BITS + 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_next_state;

    logic [CNT_W-1:0]    r_bit_cnt;
    logic [CNT_W-1:0]    r_tx_cnt;
    logic [DATA_W+1:0]   r_rx_data;
    logic [DATA_W-1:0]   r_tx_shift;
    logic                r_rx_valid;
    logic                r_miso;
    logic                r_tx_busy;
    logic                r_tx_done;
    logic                r_rd_addr_seen;

    logic                w_in_rx_state;
    logic                w_load_cnt;
    logic                w_shift_en;
    logic                w_rx_last;
    logic                w_tx_capture;
    logic                w_tx_step;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (!SS_n) w_next_state = CHK_CMD;
            end
            CHK_CMD: begin
                if (SS_n)                w_next_state = IDLE;
                else if (!MOSI)          w_next_state = WRITE;
                else if (r_rd_addr_seen) w_next_state = READ_DATA;
                else                     w_next_state = READ_ADD;
            end
            WRITE, READ_ADD, READ_DATA: begin
                if (SS_n) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // A non-zero bit counter marks the receive phase; zero means the word is in.
    always_comb begin
        w_in_rx_state = (r_state == WRITE) || (r_state == READ_ADD) || (r_state == READ_DATA);
        w_load_cnt    = (r_state == CHK_CMD) && !SS_n;
        w_shift_en    = w_in_rx_state && (r_bit_cnt != '0) && !SS_n;
        w_rx_last     = w_shift_en && (r_bit_cnt == CNT_W'(1));
        w_tx_capture  = (r_state == READ_DATA) && (r_bit_cnt == '0) && !r_tx_busy
                        && !r_tx_done && !SS_n && tx_valid;
        w_tx_step     = (r_state == READ_DATA) && r_tx_busy && !SS_n;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bit_cnt      <= '0;
            r_tx_cnt       <= '0;
            r_rx_data      <= '0;
            r_tx_shift     <= '0;
            r_rx_valid     <= 1'b0;
            r_miso         <= 1'b0;
            r_tx_busy      <= 1'b0;
            r_tx_done      <= 1'b0;
            r_rd_addr_seen <= 1'b0;
        end else begin
            r_rx_valid <= w_rx_last;
            if (SS_n) begin
                r_bit_cnt <= '0;
                r_tx_cnt  <= '0;
                r_miso    <= 1'b0;
                r_tx_busy <= 1'b0;
                r_tx_done <= 1'b0;
            end else begin
                if (w_load_cnt) begin
                    r_bit_cnt <= CNT_W'(RX_BITS);
                    r_tx_busy <= 1'b0;
                    r_tx_done <= 1'b0;
                end
                if (w_shift_en) begin
                    r_rx_data <= {r_rx_data[DATA_W:0], MOSI};
                    r_bit_cnt <= r_bit_cnt - CNT_W'(1);
                end
                if (w_rx_last && (r_state == READ_ADD)) begin
                    r_rd_addr_seen <= 1'b1;
                end
                // MSB goes out straight from the capture; the rest follows from the shifter.
                if (w_tx_capture) begin
                    r_miso     <= tx_data[DATA_W-1];
                    r_tx_shift <= {tx_data[DATA_W-2:0], 1'b0};
                    r_tx_cnt   <= CNT_W'(DATA_W - 1);
                    r_tx_busy  <= 1'b1;
                end else if (w_tx_step) begin
                    if (r_tx_cnt == '0) begin
                        r_miso         <= 1'b0;
                        r_tx_busy      <= 1'b0;
                        r_tx_done      <= 1'b1;
                        r_rd_addr_seen <= 1'b0;
                    end else begin
                        r_miso     <= r_tx_shift[DATA_W-1];
                        r_tx_shift <= {r_tx_shift[DATA_W-2:0], 1'b0};
                        r_tx_cnt   <= r_tx_cnt - CNT_W'(1);
                    end
                end
            end
        end
    end

`ifdef SPI_FRAME_ERR_EN
    logic r_sel;
    logic r_frame_err;
    logic w_frame_done;
    logic w_abort;
    logic w_sel_mismatch;

    always_comb begin
        w_frame_done   = w_in_rx_state && (r_bit_cnt == '0)
                         && ((r_state != READ_DATA) || r_tx_done);
        w_abort        = SS_n && ((r_state == CHK_CMD) || (w_in_rx_state && !w_frame_done));
        // The word's MSB after the final shift is the bit now sitting at DATA_W.
        w_sel_mismatch = w_rx_last && (r_sel != r_rx_data[DATA_W]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sel       <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_load_cnt) r_sel <= MOSI;
            r_frame_err <= w_abort || w_sel_mismatch;
        end
    end

    assign frame_err = r_frame_err;
`endif

    // Gating with SS_n drops MISO in the very cycle the master deselects.
    assign MISO     = r_miso & ~SS_n;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;

endmodule

// File: tb/tb_spi_slave_if.sv
// Directed bench for spi_slave_if: write, read, abort, reset mid-transmit and over-long frames.
module tb_spi_slave_if;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       SS_n;
    logic       MOSI;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       MISO;
    logic [9:0] rx_data;
    logic       rx_valid;
`ifdef SPI_FRAME_ERR_EN
    logic       frame_err;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int rxv_cnt  = 0;
    int miso_hi  = 0;
    logic [9:0] last_rx = '0;

    always #5 clk = ~clk;

    spi_slave_if #(.DATA_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
`ifdef SPI_FRAME_ERR_EN
        .frame_err(frame_err),
`endif
        .MISO     (MISO),
        .rx_data  (rx_data),
        .rx_valid (rx_valid)
    );

    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            rxv_cnt <= rxv_cnt + 1;
            last_rx <= rx_data;
        end
        if (MISO === 1'b1) miso_hi <= miso_hi + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic ss, input logic mosi);
        SS_n = ss;
        MOSI = mosi;
        @(posedge clk);
        #1;
    endtask

    // Returns in the cycle where rx_valid is high.
    task automatic frame(input logic sel, input logic [9:0] bits);
        cyc(1'b0, 1'b0);
        cyc(1'b0, sel);
        for (int i = 9; i >= 0; i--) cyc(1'b0, bits[i]);
    endtask

    int         cnt0;
    int         miso0;
    logic [7:0] exp_tx;
    logic [13:0] long_bits;

    initial begin
        rst_n = 1'b0; SS_n = 1'b1; MOSI = 1'b0; tx_data = '0; tx_valid = 1'b0;
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        chk("rst_miso", 32'(MISO), 0);
        chk("rst_rx_data", 32'(rx_data), 0);
        chk("rst_rx_valid", 32'(rx_valid), 0);
        chk("rst_state", 32'(dut.r_state), 0);
        chk("rst_rd_seen", 32'(dut.r_rd_addr_seen), 0);
        rst_n = 1'b1;
        cyc(1'b1, 1'b0);

        // write address then write data
        frame(1'b0, 10'b00_0000_0101);
        chk("wr_addr_valid", 32'(rx_valid), 1);
        chk("wr_addr_data", 32'(rx_data), 32'h005);
        cyc(1'b1, 1'b0);
        chk("wr_valid_one_cycle", 32'(rx_valid), 0);
        frame(1'b0, 10'b01_1010_1010);
        cyc(1'b1, 1'b0);
        chk("wr_data_count", 32'(rxv_cnt), 2);
        chk("wr_data_word", 32'(last_rx), 32'h1AA);
        chk("wr_miso_quiet", 32'(miso_hi), 0);

        // read address then read data
        frame(1'b1, 10'b10_0000_0101);
        chk("rd_addr_data", 32'(rx_data), 32'h205);
        cyc(1'b1, 1'b0);
        chk("rd_addr_seen_set", 32'(dut.r_rd_addr_seen), 1);
        frame(1'b1, 10'b11_0000_0000);
        chk("rd_data_valid", 32'(rx_valid), 1);
        cyc(1'b0, 1'b0);
        tx_data = 8'hAA; tx_valid = 1'b1;
        cyc(1'b0, 1'b0);
        tx_valid = 1'b0; tx_data = 8'h00;
        exp_tx = 8'hAA;
        for (int i = 7; i >= 0; i--) begin
            chk($sformatf("rd_miso_bit%0d", i), 32'(MISO), 32'(exp_tx[i]));
            cyc(1'b0, 1'b0);
        end
        chk("rd_miso_after", 32'(MISO), 0);
        chk("rd_addr_seen_clr", 32'(dut.r_rd_addr_seen), 0);
        cyc(1'b1, 1'b0);

        // abort after 6 of 10 bits
        cnt0 = rxv_cnt;
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1);
        cyc(1'b1, 1'b0);
        chk("abort_state", 32'(dut.r_state), 0);
`ifdef SPI_FRAME_ERR_EN
        chk("abort_frame_err", 32'(frame_err), 1);
`endif
        cyc(1'b1, 1'b0);
        chk("abort_no_valid", 32'(rxv_cnt), 32'(cnt0));
        frame(1'b0, 10'b01_0011_1100);
        cyc(1'b1, 1'b0);
        chk("abort_next_count", 32'(rxv_cnt), 32'(cnt0 + 1));
        chk("abort_next_word", 32'(last_rx), 32'h13C);

        // reset during MISO bit 3
        frame(1'b1, 10'b10_0000_0001);
        cyc(1'b1, 1'b0);
        frame(1'b1, 10'b11_0000_0000);
        cyc(1'b0, 1'b0);
        tx_data = 8'h5A; tx_valid = 1'b1;
        cyc(1'b0, 1'b0);
        tx_valid = 1'b0; tx_data = 8'h00;
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0);
        chk("rst_tx_bit3", 32'(MISO), 1);
        rst_n = 1'b0;
        cyc(1'b0, 1'b0);
        chk("rst_tx_miso", 32'(MISO), 0);
        chk("rst_tx_valid", 32'(rx_valid), 0);
        chk("rst_tx_state", 32'(dut.r_state), 0);
        chk("rst_tx_rd_seen", 32'(dut.r_rd_addr_seen), 0);
        rst_n = 1'b1;
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b1);
        chk("rst_tx_read_add", 32'(dut.r_state), 3);
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0);

        // 14 bits in a WRITE frame with a spurious tx_valid
        cnt0 = rxv_cnt;
        miso0 = miso_hi;
        long_bits = 14'b00_1100_0011_1011;
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        tx_data = 8'hFF; tx_valid = 1'b1;
        for (int i = 13; i >= 0; i--) cyc(1'b0, long_bits[i]);
        tx_valid = 1'b0; tx_data = 8'h00;
        cyc(1'b1, 1'b0);
        chk("long_one_valid", 32'(rxv_cnt), 32'(cnt0 + 1));
        chk("long_word", 32'(last_rx), 32'h0C3);
        chk("long_miso_quiet", 32'(miso_hi), 32'(miso0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
